// File: rtl/lnrv_icb2apb.sv
// ICB-slave to APB-master bridge.
// Each accepted ICB command becomes exactly one APB3/APB4 transfer followed by
// exactly one ICB response. Only one transfer is in flight at a time. An
// optional wait-cycle guard aborts an access whose pready never arrives.
module lnrv_icb2apb #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_TIMEOUT    = 256
) (
  input  logic                      clk,
  input  logic                      reset,

  // ICB command channel
  input  logic                      icb_cmd_vld,
  output logic                      icb_cmd_rdy,
  input  logic                      icb_cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]   icb_cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]   icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0] icb_cmd_wstrb,

  // ICB response channel
  output logic                      icb_rsp_vld,
  input  logic                      icb_rsp_rdy,
  output logic                      icb_rsp_err,
  output logic [P_DATA_WIDTH-1:0]   icb_rsp_rdata,

  // APB master
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [P_ADDR_WIDTH-1:0]   apb_paddr,
  output logic [P_DATA_WIDTH-1:0]   apb_pwdata,
  output logic [P_DATA_WIDTH/8-1:0] apb_pstrb,
  output logic [2:0]                apb_pprot,
  input  logic                      apb_pready,
  input  logic [P_DATA_WIDTH-1:0]   apb_prdata,
  input  logic                      apb_pslverr
);

  // The guard counter must hold the value P_TIMEOUT; keep at least one bit so
  // the declaration stays legal when the guard is disabled.
  localparam bit TIMEOUT_EN = (P_TIMEOUT > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = TIMEOUT_EN ? CNT_W'(P_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RSP    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Protection attributes are fixed: normal, secure, data access.
  assign apb_pprot = 3'b000;

  // Abort condition: the last permitted ACCESS cycle without pready.
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LIMIT);

  // Bridge FSM; every output is registered here so APB and ICB see glitch-free signals.
  // NOTE: all state here is updated with non-blocking assignments so every branch
  // reads the pre-edge values; blocking writes would make the result order-dependent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      icb_cmd_rdy   <= 1'b0;
      icb_rsp_vld   <= 1'b0;
      icb_rsp_err   <= 1'b0;
      icb_rsp_rdata <= '0;
      apb_psel      <= 1'b0;
      apb_penable   <= 1'b0;
      apb_pwrite    <= 1'b0;
      apb_paddr     <= '0;
      apb_pwdata    <= '0;
      apb_pstrb     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (icb_cmd_vld && icb_cmd_rdy) begin
            // Capture the command straight into the APB output registers;
            // they stay frozen until the next acceptance.
            apb_pwrite  <= icb_cmd_write;
            apb_paddr   <= icb_cmd_addr;
            apb_pwdata  <= icb_cmd_wdata;
            apb_pstrb   <= icb_cmd_write ? icb_cmd_wstrb : '0;
            apb_psel    <= 1'b1;
            apb_penable <= 1'b0;
            icb_cmd_rdy <= 1'b0;
            wait_cnt    <= '0;
            state       <= SETUP;
          end else begin
            // Also raises ready on the first cycle after reset release.
            icb_cmd_rdy <= 1'b1;
          end
        end

        SETUP: begin
          apb_penable <= 1'b1;
          state       <= ACCESS;
        end

        ACCESS: begin
          if (apb_pready) begin
            // pready has priority over a simultaneous timeout.
            apb_psel      <= 1'b0;
            apb_penable   <= 1'b0;
            icb_rsp_vld   <= 1'b1;
            icb_rsp_err   <= apb_pslverr;
            icb_rsp_rdata <= (!apb_pwrite && !apb_pslverr) ? apb_prdata : '0;
            state         <= RSP;
          end else if (timeout_hit) begin
            apb_psel      <= 1'b0;
            apb_penable   <= 1'b0;
            icb_rsp_vld   <= 1'b1;
            icb_rsp_err   <= 1'b1;
            icb_rsp_rdata <= '0;
            state         <= RSP;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RSP: begin
          // Raising ready together with the handshake keeps the 4-cycle cadence.
          if (icb_rsp_rdy) begin
            icb_rsp_vld <= 1'b0;
            icb_cmd_rdy <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lnrv_icb2apb.sv
// Directed testbench for lnrv_icb2apb, built with a 4-cycle wait guard.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_lnrv_icb2apb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          icb_cmd_vld;
  logic          icb_cmd_rdy;
  logic          icb_cmd_write;
  logic [AW-1:0] icb_cmd_addr;
  logic [DW-1:0] icb_cmd_wdata;
  logic [SW-1:0] icb_cmd_wstrb;
  logic          icb_rsp_vld;
  logic          icb_rsp_rdy;
  logic          icb_rsp_err;
  logic [DW-1:0] icb_rsp_rdata;
  logic          apb_psel;
  logic          apb_penable;
  logic          apb_pwrite;
  logic [AW-1:0] apb_paddr;
  logic [DW-1:0] apb_pwdata;
  logic [SW-1:0] apb_pstrb;
  logic [2:0]    apb_pprot;
  logic          apb_pready;
  logic [DW-1:0] apb_prdata;
  logic          apb_pslverr;

  int tests = 0;
  int fails = 0;

  lnrv_icb2apb #(
    .P_ADDR_WIDTH(AW),
    .P_DATA_WIDTH(DW),
    .P_TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .icb_cmd_vld  (icb_cmd_vld),
    .icb_cmd_rdy  (icb_cmd_rdy),
    .icb_cmd_write(icb_cmd_write),
    .icb_cmd_addr (icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wstrb(icb_cmd_wstrb),
    .icb_rsp_vld  (icb_rsp_vld),
    .icb_rsp_rdy  (icb_rsp_rdy),
    .icb_rsp_err  (icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata),
    .apb_psel     (apb_psel),
    .apb_penable  (apb_penable),
    .apb_pwrite   (apb_pwrite),
    .apb_paddr    (apb_paddr),
    .apb_pwdata   (apb_pwdata),
    .apb_pstrb    (apb_pstrb),
    .apb_pprot    (apb_pprot),
    .apb_pready   (apb_pready),
    .apb_prdata   (apb_prdata),
    .apb_pslverr  (apb_pslverr)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present_cmd(input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
    icb_cmd_vld   = 1'b1;
    icb_cmd_write = wr;
    icb_cmd_addr  = a;
    icb_cmd_wdata = d;
    icb_cmd_wstrb = s;
  endtask

  task automatic drop_cmd();
    icb_cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    icb_cmd_vld = 1'b0; icb_cmd_write = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wstrb = '0; icb_rsp_rdy = 1'b1;
    apb_pready = 1'b0; apb_prdata = '0; apb_pslverr = 1'b0;
    tick(); tick();
    tests++;
    if ({icb_cmd_rdy, icb_rsp_vld, icb_rsp_err, apb_psel, apb_penable, apb_pwrite, apb_pprot} !== 9'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b err=%b psel=%b pen=%b pwr=%b pprot=%b, want all 0",
               icb_cmd_rdy, icb_rsp_vld, icb_rsp_err, apb_psel, apb_penable, apb_pwrite, apb_pprot);
    end
    tests++;
    if ({icb_rsp_rdata, apb_paddr, apb_pwdata, apb_pstrb} !== '0) begin
      fails++;
      $display("FAIL reset_data: got rdata=%h paddr=%h pwdata=%h pstrb=%h, want 0",
               icb_rsp_rdata, apb_paddr, apb_pwdata, apb_pstrb);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (icb_cmd_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy_after_release: got %b want 1", icb_cmd_rdy);
    end
  endtask

  task automatic test_read_basic();
    present_cmd(1'b0, 32'h0000_1000, 32'h0, 4'hF);
    tests++;
    if (icb_cmd_rdy !== 1'b1) begin
      fails++; $display("FAIL rd_cmd_rdy: got %b want 1", icb_cmd_rdy);
    end
    tick();  // T+1: SETUP
    drop_cmd();
    apb_pready = 1'b1; apb_prdata = 32'hDEAD_BEEF;
    tests++;
    if ({apb_psel, apb_penable, apb_pwrite, icb_cmd_rdy} !== 4'b1000 || apb_paddr !== 32'h1000 || apb_pstrb !== 4'h0) begin
      fails++;
      $display("FAIL rd_setup: got psel=%b pen=%b pwr=%b rdy=%b paddr=%h pstrb=%h, want 1 0 0 0 00001000 0",
               apb_psel, apb_penable, apb_pwrite, icb_cmd_rdy, apb_paddr, apb_pstrb);
    end
    tick();  // T+2: ACCESS
    tests++;
    if ({apb_psel, apb_penable, icb_rsp_vld} !== 3'b110) begin
      fails++;
      $display("FAIL rd_access: got psel=%b pen=%b rsp_vld=%b, want 1 1 0", apb_psel, apb_penable, icb_rsp_vld);
    end
    tick();  // T+3: RSP
    apb_pready = 1'b0;
    tests++;
    if ({icb_rsp_vld, icb_rsp_err, apb_psel, apb_penable} !== 4'b1000 || icb_rsp_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL rd_rsp: got vld=%b err=%b psel=%b pen=%b rdata=%h, want 1 0 0 0 deadbeef",
               icb_rsp_vld, icb_rsp_err, apb_psel, apb_penable, icb_rsp_rdata);
    end
    tick();  // T+4: IDLE again
    tests++;
    if ({icb_rsp_vld, icb_cmd_rdy} !== 2'b01) begin
      fails++; $display("FAIL rd_done: got vld=%b rdy=%b, want 0 1", icb_rsp_vld, icb_cmd_rdy);
    end
  endtask

  task automatic test_write_wait();
    present_cmd(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0101);
    tick();  // SETUP
    drop_cmd();
    icb_cmd_addr = 32'hFFFF_FFFF; icb_cmd_wdata = '1; icb_cmd_wstrb = '1;  // must not leak
    tick();  // first ACCESS
    for (int i = 0; i < 4; i++) begin
      apb_pready = (i == 3);
      tests++;
      if (!(apb_psel && apb_penable && apb_pwrite) || apb_paddr !== 32'h2004 ||
          apb_pwdata !== 32'h1234_5678 || apb_pstrb !== 4'b0101) begin
        fails++;
        $display("FAIL wr_stable_%0d: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%b, want 1 1 1 00002004 12345678 0101",
                 i, apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb);
      end
      tick();
    end
    apb_pready = 1'b0;
    tests++;
    if ({icb_rsp_vld, icb_rsp_err, apb_psel} !== 3'b100 || icb_rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL wr_rsp: got vld=%b err=%b psel=%b rdata=%h, want 1 0 0 0",
               icb_rsp_vld, icb_rsp_err, apb_psel, icb_rsp_rdata);
    end
    tick();
    tests++;
    if (icb_rsp_vld !== 1'b0) begin
      fails++; $display("FAIL wr_single_rsp: got vld=%b want 0", icb_rsp_vld);
    end
  endtask

  task automatic test_slverr();
    present_cmd(1'b0, 32'h0000_1008, 32'h0, 4'h0);
    tick();
    drop_cmd();
    apb_pready = 1'b1; apb_pslverr = 1'b1; apb_prdata = 32'hFFFF_0000;
    tick();  // ACCESS
    tick();  // RSP
    apb_pready = 1'b0; apb_pslverr = 1'b0;
    tests++;
    if ({icb_rsp_vld, icb_rsp_err} !== 2'b11 || icb_rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL slverr_rsp: got vld=%b err=%b rdata=%h, want 1 1 0", icb_rsp_vld, icb_rsp_err, icb_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    present_cmd(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    apb_prdata = 32'h7777_7777;
    tick();
    drop_cmd();
    tick();  // first ACCESS
    for (int i = 0; i < TO; i++) begin
      tests++;
      if ({apb_psel, apb_penable, icb_rsp_vld} !== 3'b110) begin
        fails++;
        $display("FAIL to_access_%0d: got psel=%b pen=%b vld=%b, want 1 1 0", i, apb_psel, apb_penable, icb_rsp_vld);
      end
      tick();
    end
    tests++;
    if ({apb_psel, apb_penable, icb_rsp_vld, icb_rsp_err} !== 4'b0011 || icb_rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL to_abort: got psel=%b pen=%b vld=%b err=%b rdata=%h, want 0 0 1 1 0",
               apb_psel, apb_penable, icb_rsp_vld, icb_rsp_err, icb_rsp_rdata);
    end
    tick();  // handshake done
    tests++;
    if ({icb_cmd_rdy, icb_rsp_vld} !== 2'b10) begin
      fails++; $display("FAIL to_recover_rdy: got rdy=%b vld=%b, want 1 0", icb_cmd_rdy, icb_rsp_vld);
    end
    present_cmd(1'b1, 32'h0000_3004, 32'hCAFE_0001, 4'hF);
    tick();
    drop_cmd();
    tests++;
    if (!(apb_psel && apb_pwrite) || apb_paddr !== 32'h3004) begin
      fails++;
      $display("FAIL to_next_cmd: got psel=%b pwr=%b paddr=%h, want 1 1 00003004", apb_psel, apb_pwrite, apb_paddr);
    end
    apb_pready = 1'b1;
    tick(); tick();
    apb_pready = 1'b0;
    tests++;
    if ({icb_rsp_vld, icb_rsp_err} !== 2'b10) begin
      fails++; $display("FAIL to_next_rsp: got vld=%b err=%b, want 1 0", icb_rsp_vld, icb_rsp_err);
    end
    tick();

    // pready arriving on the last allowed ACCESS cycle must complete normally.
    present_cmd(1'b0, 32'h0000_3008, 32'h0, 4'h0);
    apb_prdata = 32'hA5A5_A5A5;
    tick();
    drop_cmd();
    tick();
    for (int i = 0; i < TO; i++) begin
      apb_pready = (i == TO - 1);
      tick();
    end
    apb_pready = 1'b0;
    tests++;
    if ({icb_rsp_vld, icb_rsp_err} !== 2'b10 || icb_rsp_rdata !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL to_edge_pready: got vld=%b err=%b rdata=%h, want 1 0 a5a5a5a5",
               icb_rsp_vld, icb_rsp_err, icb_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3] = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0308};
    int            setup_cyc [3];
    logic [AW-1:0] setup_addr [3];
    int            accepted = 0;
    int            setups = 0;
    int            rsps = 0;
    logic          take;
    apb_pready = 1'b1; apb_prdata = 32'h0; icb_rsp_rdy = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (apb_psel && !apb_penable) begin
        if (setups < 3) begin
          setup_cyc[setups]  = cyc;
          setup_addr[setups] = apb_paddr;
        end
        setups++;
      end
      if (icb_rsp_vld) rsps++;
      if (accepted < 3) present_cmd(1'b0, addrs[accepted], 32'h0, 4'h0);
      else drop_cmd();
      take = icb_cmd_vld && icb_cmd_rdy;
      tick();
      if (take) accepted++;
    end
    apb_pready = 1'b0;
    tests++;
    if (setups !== 3 || rsps !== 3) begin
      fails++; $display("FAIL b2b_count: got setups=%0d rsps=%0d, want 3 3", setups, rsps);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (setup_addr[i] !== addrs[i]) begin
          fails++; $display("FAIL b2b_order_%0d: got paddr=%h want %h", i, setup_addr[i], addrs[i]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (setup_cyc[i+1] - setup_cyc[i] !== 4) begin
          fails++; $display("FAIL b2b_spacing_%0d: got %0d cycles want 4", i, setup_cyc[i+1] - setup_cyc[i]);
        end
      end
    end

    // Response back-pressure: RSP must hold and no new command may enter.
    present_cmd(1'b0, 32'h0000_0400, 32'h0, 4'h0);
    tick();
    drop_cmd();
    apb_pready = 1'b1; apb_prdata = 32'h0BAD_F00D; icb_rsp_rdy = 1'b0;
    tick();
    tick();  // RSP
    apb_pready = 1'b0; apb_prdata = 32'h0;
    present_cmd(1'b1, 32'h0000_0500, 32'h1, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({icb_rsp_vld, icb_cmd_rdy, apb_psel} !== 3'b100 || icb_rsp_rdata !== 32'h0BAD_F00D) begin
        fails++;
        $display("FAIL stall_%0d: got vld=%b rdy=%b psel=%b rdata=%h, want 1 0 0 0badf00d",
                 i, icb_rsp_vld, icb_cmd_rdy, apb_psel, icb_rsp_rdata);
      end
      tick();
    end
    drop_cmd();
    icb_rsp_rdy = 1'b1;
    tick();
    tests++;
    if ({icb_rsp_vld, icb_cmd_rdy, apb_psel} !== 3'b010) begin
      fails++;
      $display("FAIL stall_release: got vld=%b rdy=%b psel=%b, want 0 1 0", icb_rsp_vld, icb_cmd_rdy, apb_psel);
    end
  endtask

  task automatic test_reset_mid_access();
    present_cmd(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    tick();
    drop_cmd();
    tick();  // ACCESS, pready low
    tests++;
    if (apb_penable !== 1'b1) begin
      fails++; $display("FAIL rst_pre_access: got pen=%b want 1", apb_penable);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({apb_psel, apb_penable, icb_rsp_vld, icb_cmd_rdy} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_async: got psel=%b pen=%b vld=%b rdy=%b, want 0 0 0 0",
               apb_psel, apb_penable, icb_rsp_vld, icb_cmd_rdy);
    end
    apb_pready = 1'b1; apb_prdata = 32'h1111_2222;
    tick();
    reset = 1'b0;
    tick();
    tests++;
    if ({icb_cmd_rdy, icb_rsp_vld, apb_psel} !== 3'b100) begin
      fails++;
      $display("FAIL rst_release: got rdy=%b vld=%b psel=%b, want 1 0 0", icb_cmd_rdy, icb_rsp_vld, apb_psel);
    end
    tick(); tick();
    tests++;
    if ({icb_rsp_vld, apb_psel} !== 2'b00) begin
      fails++; $display("FAIL rst_no_stale: got vld=%b psel=%b, want 0 0", icb_rsp_vld, apb_psel);
    end
    apb_pready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
